reservation_station: RTL and testbench

RESERVATION_STATION -- requirements
Module: reservation_station

---
 rtl/reservation_station_pkg.sv | 24 ++
 rtl/reservation_station_rs_pick.sv | 23 ++
 rtl/reservation_station.sv | 190 +++++++++++++++++++
 tb/tb_reservation_station.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/reservation_station_pkg.sv
// Shared configuration for the issue unit, ROB, SLB and reservation station:
// structure sizes and opcode encodings.
package reservation_station_pkg;

    localparam int CFG_RS_SIZE      = 16;
    localparam int CFG_ROB_SIZE_LOG = 4;
    localparam int CFG_OP_SIZE_LOG  = 6;

    typedef enum logic [CFG_OP_SIZE_LOG-1:0] {
        OP_NOP  = 6'd0,
        OP_ADD  = 6'd1,
        OP_SUB  = 6'd2,
        OP_AND  = 6'd3,
        OP_OR   = 6'd4,
        OP_XOR  = 6'd5,
        OP_SLL  = 6'd6,
        OP_SRL  = 6'd7,
        OP_SLT  = 6'd8,
        OP_ADDI = 6'd9,
        OP_BEQ  = 6'd10,
        OP_JAL  = 6'd11
    } opcode_t;

endpackage

// File: rtl/reservation_station_rs_pick.sv
// Lowest-index priority encoder; used to pick the free slot and the ready slot.
module rs_pick #(
    parameter int N = 16,
    parameter int W = $clog2(N)
) (
    input  logic [N-1:0] req,
    output logic         found,
    output logic [W-1:0] idx
);

    // Scan from the top so the lowest set bit is the last one written.
    always_comb begin
        found = 1'b0;
        idx   = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) begin
                found = 1'b1;
                idx   = W'(i);
            end
        end
    end

endmodule

// File: rtl/reservation_station.sv
// Reservation station for non-memory instructions: holds issued ops until both
// operands arrive on the CDBs, then dispatches the lowest ready entry to the ALU.
module reservation_station
    import reservation_station_pkg::*;
#(
    parameter int RS_SIZE      = CFG_RS_SIZE,
    parameter int ROB_SIZE_LOG = CFG_ROB_SIZE_LOG,
    parameter int OP_SIZE_LOG  = CFG_OP_SIZE_LOG
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    rdy,
    input  logic                    jump_rst,
    input  logic                    RS_send,
    input  logic [OP_SIZE_LOG-1:0]  op,
    input  logic [31:0]             imm,
    input  logic [31:0]             curPC,
    input  logic [ROB_SIZE_LOG-1:0] reorder,
    input  logic [31:0]             Vj,
    input  logic [ROB_SIZE_LOG-1:0] Qj,
    input  logic                    Pj,
    input  logic [31:0]             Vk,
    input  logic [ROB_SIZE_LOG-1:0] Qk,
    input  logic                    Pk,
    input  logic                    alu_cdb_valid,
    input  logic [ROB_SIZE_LOG-1:0] alu_cdb_reorder,
    input  logic [31:0]             alu_cdb_value,
    input  logic                    slb_cdb_valid,
    input  logic [ROB_SIZE_LOG-1:0] slb_cdb_reorder,
    input  logic [31:0]             slb_cdb_value,
    output logic                    rs_full,
    output logic                    alu_valid,
    output logic [OP_SIZE_LOG-1:0]  alu_op,
    output logic [31:0]             alu_Vj,
    output logic [31:0]             alu_Vk,
    output logic [31:0]             alu_imm,
    output logic [31:0]             alu_curPC,
    output logic [ROB_SIZE_LOG-1:0] alu_reorder
);

    localparam int IDX_W = $clog2(RS_SIZE);
    localparam logic [IDX_W:0] FULL_MARK = (IDX_W + 1)'(RS_SIZE - 1);

    logic [RS_SIZE-1:0]      busy;
    logic [RS_SIZE-1:0]      e_pj;
    logic [RS_SIZE-1:0]      e_pk;
    logic [OP_SIZE_LOG-1:0]  e_op  [RS_SIZE];
    logic [31:0]             e_vj  [RS_SIZE];
    logic [31:0]             e_vk  [RS_SIZE];
    logic [31:0]             e_imm [RS_SIZE];
    logic [31:0]             e_pc  [RS_SIZE];
    logic [ROB_SIZE_LOG-1:0] e_qj  [RS_SIZE];
    logic [ROB_SIZE_LOG-1:0] e_qk  [RS_SIZE];
    logic [ROB_SIZE_LOG-1:0] e_rob [RS_SIZE];

    logic [RS_SIZE-1:0] free_req;
    logic [RS_SIZE-1:0] ready_req;
    logic               free_found;
    logic               ready_found;
    logic [IDX_W-1:0]   free_idx;
    logic [IDX_W-1:0]   ready_idx;

    logic               accept;
    logic               dispatch;
    logic [IDX_W:0]     occ;
    logic [IDX_W:0]     occ_next;
    logic [31:0]        in_vj;
    logic [31:0]        in_vk;
    logic               in_pj;
    logic               in_pk;

    assign free_req  = ~busy;
    assign ready_req = busy & ~e_pj & ~e_pk;

    rs_pick #(.N(RS_SIZE), .W(IDX_W)) u_pick_free (
        .req   (free_req),
        .found (free_found),
        .idx   (free_idx)
    );

    rs_pick #(.N(RS_SIZE), .W(IDX_W)) u_pick_ready (
        .req   (ready_req),
        .found (ready_found),
        .idx   (ready_idx)
    );

    always_comb begin
        occ = '0;
        for (int i = 0; i < RS_SIZE; i++) begin
            occ = occ + (IDX_W + 1)'(busy[i]);
        end
    end

    // A free slot exists exactly when occupancy is below RS_SIZE.
    assign accept   = RS_send && rdy && !jump_rst && free_found;
    assign dispatch = rdy && !jump_rst && ready_found;
    assign occ_next = occ + (IDX_W + 1)'(accept) - (IDX_W + 1)'(dispatch);

    // Operands broadcast in the issue cycle are captured on the way in.
    always_comb begin
        in_vj = Vj;
        in_pj = Pj;
        if (Pj && alu_cdb_valid && alu_cdb_reorder == Qj) begin
            in_vj = alu_cdb_value;
            in_pj = 1'b0;
        end else if (Pj && slb_cdb_valid && slb_cdb_reorder == Qj) begin
            in_vj = slb_cdb_value;
            in_pj = 1'b0;
        end
        in_vk = Vk;
        in_pk = Pk;
        if (Pk && alu_cdb_valid && alu_cdb_reorder == Qk) begin
            in_vk = alu_cdb_value;
            in_pk = 1'b0;
        end else if (Pk && slb_cdb_valid && slb_cdb_reorder == Qk) begin
            in_vk = slb_cdb_value;
            in_pk = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy        <= '0;
            rs_full     <= 1'b0;
            alu_valid   <= 1'b0;
            alu_op      <= '0;
            alu_Vj      <= '0;
            alu_Vk      <= '0;
            alu_imm     <= '0;
            alu_curPC   <= '0;
            alu_reorder <= '0;
        end else if (!rdy) begin
            alu_valid <= 1'b0;
        end else if (jump_rst) begin
            busy      <= '0;
            rs_full   <= 1'b0;
            alu_valid <= 1'b0;
        end else begin
            for (int i = 0; i < RS_SIZE; i++) begin
                if (busy[i]) begin
                    if (e_pj[i] && alu_cdb_valid && alu_cdb_reorder == e_qj[i]) begin
                        e_vj[i] <= alu_cdb_value;
                        e_pj[i] <= 1'b0;
                    end else if (e_pj[i] && slb_cdb_valid && slb_cdb_reorder == e_qj[i]) begin
                        e_vj[i] <= slb_cdb_value;
                        e_pj[i] <= 1'b0;
                    end
                    if (e_pk[i] && alu_cdb_valid && alu_cdb_reorder == e_qk[i]) begin
                        e_vk[i] <= alu_cdb_value;
                        e_pk[i] <= 1'b0;
                    end else if (e_pk[i] && slb_cdb_valid && slb_cdb_reorder == e_qk[i]) begin
                        e_vk[i] <= slb_cdb_value;
                        e_pk[i] <= 1'b0;
                    end
                end
            end

            if (dispatch) begin
                busy[ready_idx] <= 1'b0;
                alu_valid       <= 1'b1;
                alu_op          <= e_op[ready_idx];
                alu_Vj          <= e_vj[ready_idx];
                alu_Vk          <= e_vk[ready_idx];
                alu_imm         <= e_imm[ready_idx];
                alu_curPC       <= e_pc[ready_idx];
                alu_reorder     <= e_rob[ready_idx];
            end else begin
                alu_valid <= 1'b0;
            end

            // free_idx is non-busy pre-edge, so it never collides with the slot above.
            if (accept) begin
                busy[free_idx]  <= 1'b1;
                e_op[free_idx]  <= op;
                e_imm[free_idx] <= imm;
                e_pc[free_idx]  <= curPC;
                e_rob[free_idx] <= reorder;
                e_vj[free_idx]  <= in_vj;
                e_qj[free_idx]  <= Qj;
                e_pj[free_idx]  <= in_pj;
                e_vk[free_idx]  <= in_vk;
                e_qk[free_idx]  <= Qk;
                e_pk[free_idx]  <= in_pk;
            end

            rs_full <= (occ_next >= FULL_MARK);
        end
    end

endmodule

// File: tb/tb_reservation_station.sv
// Directed bench for reservation_station: issue, wakeup, bypass, fill/drop,
// flush, stall and dispatch ordering, with hand-computed expectations.
module tb_reservation_station;
    import reservation_station_pkg::*;

    logic        clk;
    logic        rst;
    logic        rdy;
    logic        jump_rst;
    logic        RS_send;
    logic [5:0]  op;
    logic [31:0] imm;
    logic [31:0] curPC;
    logic [3:0]  reorder;
    logic [31:0] Vj;
    logic [3:0]  Qj;
    logic        Pj;
    logic [31:0] Vk;
    logic [3:0]  Qk;
    logic        Pk;
    logic        alu_cdb_valid;
    logic [3:0]  alu_cdb_reorder;
    logic [31:0] alu_cdb_value;
    logic        slb_cdb_valid;
    logic [3:0]  slb_cdb_reorder;
    logic [31:0] slb_cdb_value;
    logic        rs_full;
    logic        alu_valid;
    logic [5:0]  alu_op;
    logic [31:0] alu_Vj;
    logic [31:0] alu_Vk;
    logic [31:0] alu_imm;
    logic [31:0] alu_curPC;
    logic [3:0]  alu_reorder;

    int checks = 0;
    int errors = 0;

    reservation_station dut (
        .clk             (clk),
        .rst             (rst),
        .rdy             (rdy),
        .jump_rst        (jump_rst),
        .RS_send         (RS_send),
        .op              (op),
        .imm             (imm),
        .curPC           (curPC),
        .reorder         (reorder),
        .Vj              (Vj),
        .Qj              (Qj),
        .Pj              (Pj),
        .Vk              (Vk),
        .Qk              (Qk),
        .Pk              (Pk),
        .alu_cdb_valid   (alu_cdb_valid),
        .alu_cdb_reorder (alu_cdb_reorder),
        .alu_cdb_value   (alu_cdb_value),
        .slb_cdb_valid   (slb_cdb_valid),
        .slb_cdb_reorder (slb_cdb_reorder),
        .slb_cdb_value   (slb_cdb_value),
        .rs_full         (rs_full),
        .alu_valid       (alu_valid),
        .alu_op          (alu_op),
        .alu_Vj          (alu_Vj),
        .alu_Vk          (alu_Vk),
        .alu_imm         (alu_imm),
        .alu_curPC       (alu_curPC),
        .alu_reorder     (alu_reorder)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic issue(input logic [5:0] o, input logic [31:0] vj, input logic [3:0] qj,
                         input logic pj, input logic [31:0] vk, input logic [3:0] qk,
                         input logic pk, input logic [3:0] rob);
        RS_send = 1'b1;
        op      = o;
        Vj      = vj;
        Qj      = qj;
        Pj      = pj;
        Vk      = vk;
        Qk      = qk;
        Pk      = pk;
        reorder = rob;
    endtask

    task automatic idle();
        RS_send       = 1'b0;
        alu_cdb_valid = 1'b0;
        slb_cdb_valid = 1'b0;
    endtask

    task automatic alu_bcast(input logic [3:0] tag, input logic [31:0] val);
        alu_cdb_valid   = 1'b1;
        alu_cdb_reorder = tag;
        alu_cdb_value   = val;
    endtask

    task automatic slb_bcast(input logic [3:0] tag, input logic [31:0] val);
        slb_cdb_valid   = 1'b1;
        slb_cdb_reorder = tag;
        slb_cdb_value   = val;
    endtask

    initial begin
        rst = 1'b1; rdy = 1'b0; jump_rst = 1'b1;
        imm = 32'h100; curPC = 32'h40;
        alu_cdb_reorder = '0; alu_cdb_value = '0;
        slb_cdb_reorder = '0; slb_cdb_value = '0;
        idle();
        issue(OP_ADD, 32'h1, 4'd0, 1'b0, 32'h2, 4'd0, 1'b0, 4'd15);

        // reset wins over jump_rst and rdy; nothing issued under reset survives
        step(); step();
        chk("reset_alu_valid", 32'(alu_valid), 32'd0);
        chk("reset_rs_full", 32'(rs_full), 32'd0);
        chk("reset_alu_Vj", alu_Vj, 32'd0);
        chk("reset_alu_reorder", 32'(alu_reorder), 32'd0);
        rst = 1'b0; jump_rst = 1'b0; rdy = 1'b1;
        idle();
        step();
        chk("post_reset_no_dispatch", 32'(alu_valid), 32'd0);

        // ready op dispatches one edge after issue; back-to-back issue reuses no freed slot
        issue(OP_ADD, 32'd5, 4'd0, 1'b0, 32'd7, 4'd0, 1'b0, 4'd3);
        step();
        chk("add_issue_edge_valid", 32'(alu_valid), 32'd0);
        issue(OP_SUB, 32'h11, 4'd0, 1'b0, 32'h22, 4'd0, 1'b0, 4'd4);
        step();
        chk("add_valid", 32'(alu_valid), 32'd1);
        chk("add_Vj", alu_Vj, 32'd5);
        chk("add_Vk", alu_Vk, 32'd7);
        chk("add_reorder", 32'(alu_reorder), 32'd3);
        chk("add_op", 32'(alu_op), 32'(OP_ADD));
        chk("add_imm", alu_imm, 32'h100);
        chk("add_curPC", alu_curPC, 32'h40);
        idle();
        step();
        chk("sub_valid", 32'(alu_valid), 32'd1);
        chk("sub_reorder", 32'(alu_reorder), 32'd4);
        chk("sub_Vj", alu_Vj, 32'h11);
        step();
        chk("idle_valid", 32'(alu_valid), 32'd0);
        chk("idle_hold_reorder", 32'(alu_reorder), 32'd4);
        chk("idle_hold_Vj", alu_Vj, 32'h11);

        // wakeup on ALU CDB three cycles after issue; wrong tag on SLB is ignored
        issue(OP_ADD, 32'hBAD, 4'd2, 1'b1, 32'd1, 4'd0, 1'b0, 4'd6);
        step();
        chk("wake_wait0", 32'(alu_valid), 32'd0);
        idle();
        slb_bcast(4'd3, 32'h99);
        step();
        chk("wake_wait1", 32'(alu_valid), 32'd0);
        idle();
        step();
        chk("wake_wait2", 32'(alu_valid), 32'd0);
        alu_bcast(4'd2, 32'h10);
        step();
        chk("wake_bcast_edge", 32'(alu_valid), 32'd0);
        idle();
        step();
        chk("wake_valid", 32'(alu_valid), 32'd1);
        chk("wake_Vj", alu_Vj, 32'h10);
        chk("wake_Vk", alu_Vk, 32'd1);
        chk("wake_reorder", 32'(alu_reorder), 32'd6);

        // bypass at issue: Vj from SLB, Vk from ALU in the same cycle
        issue(OP_XOR, 32'hBAD, 4'd4, 1'b1, 32'hBAD, 4'd7, 1'b1, 4'd9);
        slb_bcast(4'd4, 32'd9);
        alu_bcast(4'd7, 32'h77);
        step();
        chk("bypass_issue_edge", 32'(alu_valid), 32'd0);
        idle();
        step();
        chk("bypass_valid", 32'(alu_valid), 32'd1);
        chk("bypass_Vj", alu_Vj, 32'd9);
        chk("bypass_Vk", alu_Vk, 32'h77);
        chk("bypass_reorder", 32'(alu_reorder), 32'd9);

        // fill: rs_full rises at 15 entries, 16th accepted, 17th dropped
        for (int i = 0; i < 15; i++) begin
            issue(OP_ADD, 32'hBAD, 4'(i), 1'b1, 32'(i), 4'd0, 1'b0, 4'(i));
            step();
            chk("fill_rs_full", 32'(rs_full), 32'(i == 14));
        end
        issue(OP_ADD, 32'hBAD, 4'd15, 1'b1, 32'd15, 4'd0, 1'b0, 4'd15);
        step();
        chk("fill16_rs_full", 32'(rs_full), 32'd1);
        issue(OP_ADD, 32'hDEAD, 4'd0, 1'b0, 32'd0, 4'd0, 1'b0, 4'd9);
        step();
        chk("drop17_edge_valid", 32'(alu_valid), 32'd0);
        idle();
        step();
        chk("drop17_no_dispatch", 32'(alu_valid), 32'd0);
        chk("drop17_rs_full", 32'(rs_full), 32'd1);
        alu_bcast(4'd3, 32'h33);
        step();
        chk("full_wake3_edge", 32'(alu_valid), 32'd0);
        idle();
        step();
        chk("full_disp3_valid", 32'(alu_valid), 32'd1);
        chk("full_disp3_reorder", 32'(alu_reorder), 32'd3);
        chk("full_disp3_Vj", alu_Vj, 32'h33);
        chk("full_occ15_rs_full", 32'(rs_full), 32'd1);
        alu_bcast(4'd7, 32'h70);
        step();
        chk("full_wake7_rs_full", 32'(rs_full), 32'd1);
        idle();
        step();
        chk("full_disp7_valid", 32'(alu_valid), 32'd1);
        chk("full_disp7_reorder", 32'(alu_reorder), 32'd7);
        chk("full_occ14_rs_full", 32'(rs_full), 32'd0);

        jump_rst = 1'b1;
        step();
        chk("flush1_rs_full", 32'(rs_full), 32'd0);
        chk("flush1_valid", 32'(alu_valid), 32'd0);
        jump_rst = 1'b0;

        // eight blocked entries, then flush with a concurrent send
        for (int i = 0; i < 8; i++) begin
            issue(OP_OR, 32'hBAD, 4'(i), 1'b1, 32'd0, 4'd0, 1'b0, 4'(i));
            step();
        end
        jump_rst = 1'b1;
        issue(OP_ADD, 32'd1, 4'd0, 1'b0, 32'd2, 4'd0, 1'b0, 4'd12);
        alu_bcast(4'd0, 32'h5);
        step();
        chk("flush2_valid", 32'(alu_valid), 32'd0);
        chk("flush2_rs_full", 32'(rs_full), 32'd0);
        jump_rst = 1'b0;
        idle();
        for (int i = 0; i < 8; i++) begin
            alu_bcast(4'(i), 32'(i + 100));
            step();
            chk("flush2_no_dispatch", 32'(alu_valid), 32'd0);
        end
        idle();
        step();
        chk("flush2_no_dispatch_end", 32'(alu_valid), 32'd0);
        for (int i = 0; i < 15; i++) begin
            issue(OP_ADD, 32'hBAD, 4'(i), 1'b1, 32'd0, 4'd0, 1'b0, 4'(i));
            step();
            chk("refill_rs_full", 32'(rs_full), 32'(i == 14));
        end
        idle();
        jump_rst = 1'b1;
        step();
        jump_rst = 1'b0;

        // entries 1 and 5 ready together; a 3-cycle stall separates their dispatch
        for (int i = 0; i < 6; i++) begin
            issue(OP_AND, 32'hBAD, 4'(10 + i), 1'b1, 32'd0, 4'd0, 1'b0, 4'(i));
            step();
        end
        idle();
        alu_bcast(4'd11, 32'h11);
        slb_bcast(4'd15, 32'h55);
        step();
        chk("order_wake_edge", 32'(alu_valid), 32'd0);
        idle();
        step();
        chk("order_first_valid", 32'(alu_valid), 32'd1);
        chk("order_first_reorder", 32'(alu_reorder), 32'd1);
        chk("order_first_Vj", alu_Vj, 32'h11);
        rdy = 1'b0;
        issue(OP_ADD, 32'd1, 4'd0, 1'b0, 32'd2, 4'd0, 1'b0, 4'd12);
        alu_bcast(4'd10, 32'hEE);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("stall_valid", 32'(alu_valid), 32'd0);
            chk("stall_rs_full", 32'(rs_full), 32'd0);
        end
        rdy = 1'b1;
        idle();
        step();
        chk("order_second_valid", 32'(alu_valid), 32'd1);
        chk("order_second_reorder", 32'(alu_reorder), 32'd5);
        chk("order_second_Vj", alu_Vj, 32'h55);
        step();
        chk("stall_cdb_ignored", 32'(alu_valid), 32'd0);
        alu_bcast(4'd10, 32'hAB);
        step();
        idle();
        step();
        chk("entry0_valid", 32'(alu_valid), 32'd1);
        chk("entry0_reorder", 32'(alu_reorder), 32'd0);
        chk("entry0_Vj", alu_Vj, 32'hAB);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
